// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - interrupt entry/exit sequencer for a 5-stage pipeline
// Drains the pipeline, pushes the return PC as two words, vectors, and undoes it all on RTI.
module interrupt_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_interrupt,
  input  logic [31:0] i_pc_in,
  input  logic        i_branch_flush,
  input  logic        i_rti_decoded,
  output logic        o_stall_fetch,
  output logic        o_push_valid,
  output logic [15:0] o_push_data,
  output logic        o_pc_load,
  output logic [31:0] o_pc_load_addr,
  output logic        o_save_flags,
  output logic        o_restore_flags,
  output logic        o_in_service
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAIN     = 3'd1,
    S_PUSH_HI   = 3'd2,
    S_PUSH_LO   = 3'd3,
    S_LOAD_VEC  = 3'd4,
    S_SERVICE   = 3'd5,
    S_RTI_DRAIN = 3'd6,
    S_RTI_DONE  = 3'd7
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

  state_t      r_state;
  logic        r_pending;
  logic        r_irq_d;
  logic [2:0]  r_counter;
  logic [31:0] r_saved_pc;

  logic        r_stall_fetch;
  logic        r_push_valid;
  logic [15:0] r_push_data;
  logic        r_pc_load;
  logic [31:0] r_pc_load_addr;
  logic        r_save_flags;
  logic        r_restore_flags;
  logic        r_in_service;

  state_t      w_next;
  logic        w_edge;
  logic        w_latch;
  logic [31:0] w_pc_src;

  assign w_edge   = i_interrupt & ~r_irq_d;
  assign w_latch  = (r_state == S_DRAIN) && (r_counter == 3'd0);
  // The high word goes out on the same edge that captures the PC, so bypass the register.
  assign w_pc_src = w_latch ? i_pc_in : r_saved_pc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (r_pending && !i_branch_flush) w_next = S_DRAIN;
      S_DRAIN:     if (r_counter == 3'd0) w_next = S_PUSH_HI;
      S_PUSH_HI:   w_next = S_PUSH_LO;
      S_PUSH_LO:   w_next = S_LOAD_VEC;
      S_LOAD_VEC:  w_next = S_SERVICE;
      S_SERVICE:   if (i_rti_decoded) w_next = S_RTI_DRAIN;
      S_RTI_DRAIN: if (r_counter == 3'd0) w_next = S_RTI_DONE;
      S_RTI_DONE:  w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_pending       <= 1'b0;
      r_irq_d         <= 1'b0;
      r_counter       <= 3'd0;
      r_saved_pc      <= 32'd0;
      r_stall_fetch   <= 1'b0;
      r_push_valid    <= 1'b0;
      r_push_data     <= 16'd0;
      r_pc_load       <= 1'b0;
      r_pc_load_addr  <= 32'd0;
      r_save_flags    <= 1'b0;
      r_restore_flags <= 1'b0;
      r_in_service    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_irq_d <= i_interrupt;

      // Only one request is remembered; it is consumed when the vector is taken.
      if (r_state == S_PUSH_LO) r_pending <= 1'b0;
      else if (w_edge)          r_pending <= 1'b1;

      if ((r_state == S_IDLE && w_next == S_DRAIN) ||
          (r_state == S_SERVICE && w_next == S_RTI_DRAIN))
        r_counter <= CNT_INIT;
      else if ((r_state == S_DRAIN || r_state == S_RTI_DRAIN) && r_counter != 3'd0)
        r_counter <= r_counter - 3'd1;

      if (w_latch) r_saved_pc <= i_pc_in;

      // Outputs are decoded from the next state so they line up with the state register.
      r_stall_fetch   <= (w_next == S_DRAIN) || (w_next == S_PUSH_HI) || (w_next == S_PUSH_LO) ||
                         (w_next == S_LOAD_VEC) || (w_next == S_RTI_DRAIN);
      r_push_valid    <= (w_next == S_PUSH_HI) || (w_next == S_PUSH_LO);
      r_push_data     <= (w_next == S_PUSH_HI) ? w_pc_src[31:16] :
                         (w_next == S_PUSH_LO) ? w_pc_src[15:0]  : 16'd0;
      r_pc_load       <= (w_next == S_LOAD_VEC);
      r_pc_load_addr  <= (w_next == S_LOAD_VEC) ? VECTOR_ADDR : 32'd0;
      r_save_flags    <= (w_next == S_LOAD_VEC);
      r_restore_flags <= (w_next == S_RTI_DONE);
      r_in_service    <= (w_next == S_SERVICE) || (w_next == S_RTI_DRAIN) || (w_next == S_RTI_DONE);
    end
  end

  assign o_stall_fetch   = r_stall_fetch;
  assign o_push_valid    = r_push_valid;
  assign o_push_data     = r_push_data;
  assign o_pc_load       = r_pc_load;
  assign o_pc_load_addr  = r_pc_load_addr;
  assign o_save_flags    = r_save_flags;
  assign o_restore_flags = r_restore_flags;
  assign o_in_service    = r_in_service;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer
// Stimulus queues expected pulses; a negedge monitor pops and compares them.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq = 1'b0;
  logic        bf = 1'b0;
  logic        rti = 1'b0;
  logic [31:0] pc = 32'd0;

  logic        stall_fetch, push_valid, pc_load, save_flags, restore_flags, in_service;
  logic [15:0] push_data;
  logic [31:0] pc_load_addr;

  interrupt_sequencer #(.DRAIN_CYCLES(3), .VECTOR_ADDR(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_interrupt(irq), .i_pc_in(pc),
    .i_branch_flush(bf), .i_rti_decoded(rti),
    .o_stall_fetch(stall_fetch), .o_push_valid(push_valid), .o_push_data(push_data),
    .o_pc_load(pc_load), .o_pc_load_addr(pc_load_addr), .o_save_flags(save_flags),
    .o_restore_flags(restore_flags), .o_in_service(in_service)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [7:0]  kind;
    logic [31:0] data;
    logic [23:0] when;
  } ev_t;
  ev_t exp_q[$];

  localparam logic [7:0] K_PUSH = 8'd1, K_LOAD = 8'd2, K_REST = 8'd3;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [63:0] outs();
    return 64'({stall_fetch, push_valid, push_data, pc_load, pc_load_addr,
                save_flags, restore_flags, in_service});
  endfunction

  task automatic expect_ev(input logic [7:0] k, input logic [31:0] d, input int c);
    exp_q.push_back('{kind: k, data: d, when: c[23:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) tick();
    @(negedge clk);
  endtask

  task automatic entry(input logic [31:0] p, output int c0);
    tick();
    pc  = p;
    irq = 1'b1;
    c0  = cyc;
    expect_ev(K_PUSH, {16'd0, p[31:16]}, c0 + 5);
    expect_ev(K_PUSH, {16'd0, p[15:0]},  c0 + 6);
    expect_ev(K_LOAD, 32'h0000_0000,     c0 + 7);
  endtask

  task automatic rti_exit(output int r);
    tick();
    rti = 1'b1;
    r   = cyc;
    expect_ev(K_REST, 32'd0, r + 4);
    tick();
    rti = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    int   n;
    ev_t  got;
    ev_t  e;
    n = int'(push_valid) + int'(pc_load) + int'(restore_flags);
    if (n > 1) check("pulse_exclusive", 64'(n), 64'd1);
    if (n == 1 || save_flags) begin
      check("save_with_load", 64'(save_flags), 64'(pc_load));
      got.kind = push_valid ? K_PUSH : (pc_load ? K_LOAD : K_REST);
      got.data = push_valid ? {16'd0, push_data} : (pc_load ? pc_load_addr : 32'd0);
      got.when = cyc[23:0];
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got %h expected none (cycle %0d)", got, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    int c0, r, s, rc, base;
    // Reset state and idle behaviour.
    repeat (3) tick();
    @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    tick();
    rst_n = 1'b1;
    base = cyc;
    for (int k = 1; k <= 10; k += 3) begin
      at(base + k);
      check("idle_outs", outs(), 64'd0);
    end

    // Basic entry: pushes 0x0001, 0x2345, vector, then service and RTI exit.
    entry(32'h0001_2345, c0);
    at(c0 + 1); check("no_stall_pending", 64'(stall_fetch), 64'd0);
    at(c0 + 2); check("drain_stall_0", 64'(stall_fetch), 64'd1);
    at(c0 + 4); check("drain_stall_2", 64'(stall_fetch), 64'd1);
    at(c0 + 8); check("in_service", 64'({in_service, stall_fetch}), 64'b10);
    tick();
    irq = 1'b0;
    rti_exit(r);
    at(r + 1); check("rti_drain", 64'({stall_fetch, in_service}), 64'b11);
    at(r + 3); check("rti_drain_end", 64'({stall_fetch, in_service}), 64'b11);
    at(r + 4); check("rti_done", 64'({stall_fetch, in_service}), 64'b01);
    at(r + 5); check("back_idle", outs(), 64'd0);

    // Edge with branch flush: entry waits for flush to drop, saves branch target.
    tick();
    pc  = 32'h0000_0000;
    irq = 1'b1;
    bf  = 1'b1;
    c0  = cyc;
    tick();
    pc  = 32'h0000_0040;
    tick();
    bf  = 1'b0;
    irq = 1'b0;
    expect_ev(K_PUSH, 32'h0000_0000, c0 + 6);
    expect_ev(K_PUSH, 32'h0000_0040, c0 + 7);
    expect_ev(K_LOAD, 32'h0000_0000, c0 + 8);
    at(c0 + 2); check("flush_defers", 64'(stall_fetch), 64'd0);
    at(c0 + 3); check("flush_drain", 64'(stall_fetch), 64'd1);
    at(c0 + 9); check("flush_service", 64'(in_service), 64'd1);
    rti_exit(r);
    at(r + 6);

    // Second edge during service is held, then re-entered right after RTI.
    entry(32'hABCD_1234, c0);
    at(c0 + 8);
    tick(); irq = 1'b0;
    tick(); irq = 1'b1; s = cyc;
    tick(); irq = 1'b0;
    at(s + 3); check("held_in_service", 64'({in_service, stall_fetch}), 64'b10);
    rti_exit(r);
    expect_ev(K_PUSH, 32'h0000_ABCD, r + 9);
    expect_ev(K_PUSH, 32'h0000_1234, r + 10);
    expect_ev(K_LOAD, 32'h0000_0000, r + 11);
    at(r + 5); check("reentry_idle", 64'(stall_fetch), 64'd0);
    at(r + 6); check("reentry_drain", 64'(stall_fetch), 64'd1);
    at(r + 12); check("reentry_service", 64'(in_service), 64'd1);
    rti_exit(r);
    at(r + 6);

    // Reset during PUSH_LO: outputs drop at once, no resumed sequence.
    tick();
    pc  = 32'h5555_AAAA;
    irq = 1'b1;
    c0  = cyc;
    expect_ev(K_PUSH, 32'h0000_5555, c0 + 5);
    tick();
    irq = 1'b0;
    while (cyc < c0 + 6) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_push", outs(), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rc = cyc;
    at(rc + 15); check("no_resume", outs(), 64'd0);

    // Interrupt held high: a single entry sequence.
    tick();
    pc  = 32'h0000_BEEF;
    irq = 1'b1;
    c0  = cyc;
    expect_ev(K_PUSH, 32'h0000_0000, c0 + 5);
    expect_ev(K_PUSH, 32'h0000_BEEF, c0 + 6);
    expect_ev(K_LOAD, 32'h0000_0000, c0 + 7);
    while (cyc < c0 + 20) tick();
    irq = 1'b0;
    rti_exit(r);
    at(r + 15); check("held_single_entry", outs(), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
